seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: 32-bit sequential restoring divider, signed or unsigned.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the accepting edge
// ITER  | one restoring step per cycle while cnt < 32, then a settle cycle
// FIX   | sign correction, result registers loaded
// DONE  | done pulse for one cycle, then back to IDLE
//
// Fixed latency: start sampled at edge E0 gives done high after edge E0+34.
// b == 0 needs no special path: the restoring loop naturally produces an
// all-ones quotient and a remainder equal to |a|, and the usual sign fix
// turns that remainder back into the original a.
module seq_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic        signedOp,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divByZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Dividend magnitude shifts out of the MSB while quotient bits enter the LSB.
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_q, rem_d;
    logic        sgn_op_q, sgn_op_d;
    logic        neg_rem_q, neg_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        dbz_q, dbz_d;
    logic [31:0] quo_out_q, quo_out_d;
    logic [31:0] rem_out_q, rem_out_d;
    logic        dbz_out_q, dbz_out_d;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [33:0] trial;
    logic [33:0] diff;

    assign a_mag = (signedOp && a[31]) ? (~a + 32'd1) : a;
    assign b_mag = (signedOp && b[31]) ? (~b + 32'd1) : b;

    // One restoring step: shift next dividend bit in, trial-subtract divisor.
    assign trial = {rem_q, dvd_q[31]};
    assign diff  = trial - {2'b00, dvs_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            sgn_op_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            dbz_q     <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            sgn_op_q  <= sgn_op_d;
            neg_rem_q <= neg_rem_d;
            neg_quo_q <= neg_quo_d;
            dbz_q     <= dbz_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        sgn_op_d  = sgn_op_q;
        neg_rem_d = neg_rem_q;
        neg_quo_d = neg_quo_q;
        dbz_d     = dbz_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_out_d = dbz_out_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = a_mag;
                    dvs_d     = b_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    sgn_op_d  = signedOp;
                    neg_rem_d = a[31];
                    neg_quo_d = a[31] ^ b[31];
                    dbz_d     = (b == 32'd0);
                    state_d   = ITER;
                end
            end
            ITER: begin
                if (cnt_q == 6'd32) begin
                    state_d = FIX;
                end else begin
                    if (!diff[33]) begin
                        rem_d = diff[32:0];
                        dvd_d = {dvd_q[30:0], 1'b1};
                    end else begin
                        rem_d = trial[32:0];
                        dvd_d = {dvd_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end
            FIX: begin
                if (sgn_op_q && neg_quo_q && !dbz_q) begin
                    quo_out_d = ~dvd_q + 32'd1;
                end else begin
                    quo_out_d = dvd_q;
                end
                if (sgn_op_q && neg_rem_q) begin
                    rem_out_d = ~rem_q[31:0] + 32'd1;
                end else begin
                    rem_out_d = rem_q[31:0];
                end
                dbz_out_d = dbz_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ITER) || (state_q == FIX);
    assign done      = (state_q == DONE);
    assign quotient  = quo_out_q;
    assign remainder = rem_out_q;
    assign divByZero = dbz_out_q;

endmodule
